// File: rtl/vend_pkg.sv
// vend_pkg: shared types for the vending controller.
//   vend_state_t : encoded controller state (also driven on the 'state' port)
//   IDX_W(n)     : index width for an n-entry table
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CREDIT   = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } vend_state_t;

  function automatic int IDX_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vend_item_table.sv
// vend_item_table: per-item cost and stock registers.
//   rd_idx_i            : item whose cost/stock is presented combinationally
//   rd_cost_o/rd_stock_o: cost and stock of rd_idx_i (pre-write values)
//   cost_wr_*           : cost table write
//   restock_*           : stock load
//   dec_en_i            : purchase of rd_idx_i this cycle (stock -1)
module vend_item_table
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS = 8,
  parameter int MONEY_W   = 8,
  parameter int STOCK_W   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [IDX_W(NUM_ITEMS)-1:0]  rd_idx_i,
  output logic [MONEY_W-1:0]           rd_cost_o,
  output logic [STOCK_W-1:0]           rd_stock_o,
  input  logic                         cost_wr_en_i,
  input  logic [IDX_W(NUM_ITEMS)-1:0]  cost_wr_idx_i,
  input  logic [MONEY_W-1:0]           cost_wr_data_i,
  input  logic                         restock_en_i,
  input  logic [IDX_W(NUM_ITEMS)-1:0]  restock_idx_i,
  input  logic [STOCK_W-1:0]           restock_qty_i,
  input  logic                         dec_en_i
);
  localparam int IW = IDX_W(NUM_ITEMS);

  logic [NUM_ITEMS-1:0][MONEY_W-1:0] cost_all;
  logic [NUM_ITEMS-1:0][STOCK_W-1:0] stock_all;

  assign rd_cost_o  = cost_all[rd_idx_i];
  assign rd_stock_o = stock_all[rd_idx_i];

  for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_item
    logic [MONEY_W-1:0] cost_q;
    logic [STOCK_W-1:0] stock_q;
    logic               wr_c, wr_s, dec;

    assign wr_c = cost_wr_en_i && (cost_wr_idx_i == IW'(i));
    assign wr_s = restock_en_i && (restock_idx_i == IW'(i));
    assign dec  = dec_en_i && (rd_idx_i == IW'(i));

    always_ff @(posedge clk) begin
      if (!reset) begin
        cost_q  <= '0;
        stock_q <= '0;
      end else begin
        if (wr_c) cost_q <= cost_wr_data_i;
        // restock racing a purchase of the same item: the sold unit comes
        // out of the new quantity
        if (wr_s && dec)
          stock_q <= (restock_qty_i == '0) ? '0 : restock_qty_i - STOCK_W'(1);
        else if (wr_s)
          stock_q <= restock_qty_i;
        else if (dec)
          stock_q <= stock_q - STOCK_W'(1);
      end
    end

    assign cost_all[i]  = cost_q;
    assign stock_all[i] = stock_q;
  end

endmodule

// File: rtl/vend_controller.sv
// vend_controller: multi-item vending controller.
//   coin_valid/coin_value -> coin_reject      : coin intake, capped at MAX_CREDIT
//   item_sel/buy_button/cancel_button         : purchase / refund requests
//   cost_wr_*/restock_*                       : table maintenance, any state
//   credit, state                             : current credit and FSM state
//   dispense_valid/idx, dispense_ready        : dispense handshake
//   change_valid/amount, change_ready         : refund handshake
//   err_sold_out/err_insufficient             : one-cycle error pulses
// All outputs are registered; reset is synchronous active-low.
module vend_controller
  import vend_pkg::*;
#(
  parameter int MONEY_W     = 8,
  parameter int NUM_ITEMS   = 8,
  parameter int STOCK_W     = 4,
  parameter int MAX_CREDIT  = 200,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         coin_valid,
  input  logic [MONEY_W-1:0]           coin_value,
  output logic                         coin_reject,
  input  logic [IDX_W(NUM_ITEMS)-1:0]  item_sel,
  input  logic                         buy_button,
  input  logic                         cancel_button,
  input  logic                         cost_wr_en,
  input  logic [IDX_W(NUM_ITEMS)-1:0]  cost_wr_idx,
  input  logic [MONEY_W-1:0]           cost_wr_data,
  input  logic                         restock_en,
  input  logic [IDX_W(NUM_ITEMS)-1:0]  restock_idx,
  input  logic [STOCK_W-1:0]           restock_qty,
  output logic [MONEY_W-1:0]           credit,
  output logic                         dispense_valid,
  output logic [IDX_W(NUM_ITEMS)-1:0]  dispense_idx,
  input  logic                         dispense_ready,
  output logic                         change_valid,
  output logic [MONEY_W-1:0]           change_amount,
  input  logic                         change_ready,
  output logic                         err_sold_out,
  output logic                         err_insufficient,
  output vend_state_t                  state
);
  localparam int IW = IDX_W(NUM_ITEMS);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  vend_state_t        state_q, state_d;
  logic [MONEY_W-1:0] credit_q, credit_d, chg_q;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               dv_q, cv_q, rej_q, so_q, ins_q;
  logic               rej_d, so_d, ins_d, buy_ok, coin_ok;
  logic [MONEY_W:0]   sum;
  logic [MONEY_W-1:0] item_cost;
  logic [STOCK_W-1:0] item_stock;

  vend_item_table #(
    .NUM_ITEMS(NUM_ITEMS), .MONEY_W(MONEY_W), .STOCK_W(STOCK_W)
  ) u_tbl (
    .clk(clk), .reset(reset),
    .rd_idx_i(item_sel), .rd_cost_o(item_cost), .rd_stock_o(item_stock),
    .cost_wr_en_i(cost_wr_en), .cost_wr_idx_i(cost_wr_idx), .cost_wr_data_i(cost_wr_data),
    .restock_en_i(restock_en), .restock_idx_i(restock_idx), .restock_qty_i(restock_qty),
    .dec_en_i(buy_ok)
  );

  // one extra bit so the cap check cannot be fooled by wrap-around
  assign sum     = {1'b0, credit_q} + {1'b0, coin_value};
  assign coin_ok = coin_valid && !buy_button && !cancel_button &&
                   (state_q == IDLE || state_q == CREDIT) &&
                   (sum <= (MONEY_W+1)'(MAX_CREDIT));

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    tmo_d    = '0;        // counter restarts unless CREDIT sits idle
    idx_d    = idx_q;
    so_d     = 1'b0;
    ins_d    = 1'b0;
    buy_ok   = 1'b0;
    rej_d    = coin_valid && !coin_ok;
    if (coin_ok) credit_d = sum[MONEY_W-1:0];
    case (state_q)
      IDLE:     if (coin_ok) state_d = CREDIT;
      CREDIT: begin
        if (cancel_button) state_d = CHANGE;
        else if (buy_button) begin
          if (item_stock == '0)         so_d = 1'b1;
          else if (credit_q < item_cost) ins_d = 1'b1;
          else begin
            buy_ok   = 1'b1;
            idx_d    = item_sel;
            credit_d = credit_q - item_cost;
            state_d  = DISPENSE;
          end
        end else if (!coin_ok) begin
          if (tmo_q == TW'(TIMEOUT_CYC-1)) state_d = CHANGE;
          else                             tmo_d   = tmo_q + TW'(1);
        end
      end
      DISPENSE: if (dispense_ready) state_d = CHANGE;
      CHANGE: if (change_ready) begin
        credit_d = '0;
        state_d  = IDLE;
      end
    endcase
    // nothing to refund: skip the change handshake entirely
    if (state_d == CHANGE && credit_d == '0) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      credit_q <= '0;
      tmo_q    <= '0;
      idx_q    <= '0;
      dv_q     <= 1'b0;
      cv_q     <= 1'b0;
      chg_q    <= '0;
      rej_q    <= 1'b0;
      so_q     <= 1'b0;
      ins_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      tmo_q    <= tmo_d;
      idx_q    <= (state_d == DISPENSE) ? idx_d : '0;
      dv_q     <= (state_d == DISPENSE);
      cv_q     <= (state_d == CHANGE);
      chg_q    <= (state_d == CHANGE) ? credit_d : '0;
      rej_q    <= rej_d;
      so_q     <= so_d;
      ins_q    <= ins_d;
    end
  end

  assign state            = state_q;
  assign credit           = credit_q;
  assign dispense_valid   = dv_q;
  assign dispense_idx     = idx_q;
  assign change_valid     = cv_q;
  assign change_amount    = chg_q;
  assign coin_reject      = rej_q;
  assign err_sold_out     = so_q;
  assign err_insufficient = ins_q;

endmodule

// File: tb/tb_vend_controller.sv
// tb_vend_controller: directed scenarios followed by random traffic, every
// cycle compared against a behavioural model of the vending rules.
module tb_vend_controller;
  import vend_pkg::*;

  localparam int MW = 8, NI = 8, SW = 4, MAXC = 200, TMO = 16, IW = 3;

  logic clk = 1'b0, reset = 1'b0;
  logic coin_valid = 0, buy_button = 0, cancel_button = 0;
  logic cost_wr_en = 0, restock_en = 0, dispense_ready = 0, change_ready = 0;
  logic [MW-1:0] coin_value = '0, cost_wr_data = '0;
  logic [IW-1:0] item_sel = '0, cost_wr_idx = '0, restock_idx = '0;
  logic [SW-1:0] restock_qty = '0;
  logic coin_reject, dispense_valid, change_valid, err_sold_out, err_insufficient;
  logic [MW-1:0] credit, change_amount;
  logic [IW-1:0] dispense_idx;
  vend_state_t   state;

  always #5 clk = ~clk;

  vend_controller #(.MONEY_W(MW), .NUM_ITEMS(NI), .STOCK_W(SW),
                    .MAX_CREDIT(MAXC), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset),
    .coin_valid(coin_valid), .coin_value(coin_value), .coin_reject(coin_reject),
    .item_sel(item_sel), .buy_button(buy_button), .cancel_button(cancel_button),
    .cost_wr_en(cost_wr_en), .cost_wr_idx(cost_wr_idx), .cost_wr_data(cost_wr_data),
    .restock_en(restock_en), .restock_idx(restock_idx), .restock_qty(restock_qty),
    .credit(credit),
    .dispense_valid(dispense_valid), .dispense_idx(dispense_idx), .dispense_ready(dispense_ready),
    .change_valid(change_valid), .change_amount(change_amount), .change_ready(change_ready),
    .err_sold_out(err_sold_out), .err_insufficient(err_insufficient), .state(state)
  );

  int tests = 0, fails = 0;

  // model: mode 0 idle, 1 collecting credit, 2 dispensing, 3 refunding
  int m_mode = 0, m_credit = 0, m_idle = 0, m_item = 0;
  int m_cost[NI], m_stock[NI];
  bit m_rej = 0, m_so = 0, m_ins = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic m_refund();
    m_mode = (m_credit > 0) ? 3 : 0;
  endtask

  task automatic model_edge();
    bit take, sold;
    int sel, coin;
    sel  = int'(item_sel);
    coin = int'(coin_value);
    sold = 0;
    if (!reset) begin
      m_mode = 0; m_credit = 0; m_idle = 0; m_item = 0;
      m_rej = 0; m_so = 0; m_ins = 0;
      for (int i = 0; i < NI; i++) begin m_cost[i] = 0; m_stock[i] = 0; end
      return;
    end
    take  = coin_valid && (m_mode == 0 || m_mode == 1) && !buy_button &&
            !cancel_button && (m_credit + coin <= MAXC);
    m_rej = coin_valid && !take;
    m_so  = 0;
    m_ins = 0;
    case (m_mode)
      0: if (take) begin m_credit += coin; m_mode = 1; m_idle = 0; end
      1: begin
        if (cancel_button) m_refund();
        else if (buy_button) begin
          m_idle = 0;
          if (m_stock[sel] == 0) m_so = 1;
          else if (m_credit < m_cost[sel]) m_ins = 1;
          else begin
            sold = 1;
            m_credit -= m_cost[sel];
            m_stock[sel] -= 1;
            m_item = sel;
            m_mode = 2;
          end
        end else if (take) begin
          m_credit += coin;
          m_idle = 0;
        end else begin
          m_idle++;
          if (m_idle == TMO) m_refund();
        end
      end
      2: if (dispense_ready) m_refund();
      default: if (change_ready) begin m_credit = 0; m_mode = 0; end
    endcase
    if (cost_wr_en) m_cost[cost_wr_idx] = int'(cost_wr_data);
    if (restock_en) begin
      if (sold && int'(restock_idx) == sel)
        m_stock[restock_idx] = (restock_qty > 0) ? int'(restock_qty) - 1 : 0;
      else
        m_stock[restock_idx] = int'(restock_qty);
    end
  endtask

  task automatic check_outputs();
    chk("state", state, m_mode);
    chk("credit", credit, m_credit);
    chk("coin_reject", coin_reject, m_rej);
    chk("err_sold_out", err_sold_out, m_so);
    chk("err_insufficient", err_insufficient, m_ins);
    chk("dispense_valid", dispense_valid, (m_mode == 2));
    chk("dispense_idx", dispense_idx, (m_mode == 2) ? m_item : 0);
    chk("change_valid", change_valid, (m_mode == 3));
    chk("change_amount", change_amount, (m_mode == 3) ? m_credit : 0);
  endtask

  // one clock: model consumes the same inputs the DUT sees, then compare
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic coin(input int v);
    coin_valid = 1; coin_value = MW'(v); step(); coin_valid = 0;
  endtask
  task automatic buy(input int i);
    buy_button = 1; item_sel = IW'(i); step(); buy_button = 0;
  endtask
  task automatic cancel();
    cancel_button = 1; step(); cancel_button = 0;
  endtask
  task automatic wr_cost(input int i, input int c);
    cost_wr_en = 1; cost_wr_idx = IW'(i); cost_wr_data = MW'(c); step(); cost_wr_en = 0;
  endtask
  task automatic restock(input int i, input int q);
    restock_en = 1; restock_idx = IW'(i); restock_qty = SW'(q); step(); restock_en = 0;
  endtask
  task automatic take_change();
    change_ready = 1; step(); change_ready = 0;
  endtask

  initial begin
    // reset
    reset = 0; step(); step();
    chk("rst_state", state, 0);
    chk("rst_credit", credit, 0);
    reset = 1;

    // exact-change purchase, no refund afterwards
    wr_cost(2, 50); restock(2, 3);
    coin(25); coin(25);
    chk("p1_credit", credit, 50);
    buy(2);
    chk("p1_dv", dispense_valid, 1);
    chk("p1_idx", dispense_idx, 2);
    chk("p1_credit0", credit, 0);
    step(); step();                        // idx must hold while not ready
    chk("p1_idx_hold", dispense_idx, 2);
    dispense_ready = 1; step(); dispense_ready = 0;
    chk("p1_idle", state, 0);
    chk("p1_no_chg", change_valid, 0);

    // purchase with change
    wr_cost(1, 60); restock(1, 5);
    coin(50); coin(50); buy(1);
    dispense_ready = 1; step(); dispense_ready = 0;
    chk("p2_cv", change_valid, 1);
    chk("p2_amt", change_amount, 40);
    step();
    take_change();
    chk("p2_idle", state, 0);
    chk("p2_credit", credit, 0);

    // credit cap
    coin(100); coin(90); coin(25);
    chk("p3_rej", coin_reject, 1);
    chk("p3_190", credit, 190);
    coin(10);
    chk("p3_200", credit, 200);
    cancel(); take_change();

    // sold out, insufficient
    wr_cost(4, 10); restock(4, 0);
    coin(100); buy(4);
    chk("p4_so", err_sold_out, 1);
    chk("p4_state", state, 1);
    wr_cost(5, 150); restock(5, 2); buy(5);
    chk("p4_ins", err_insufficient, 1);
    cancel(); take_change();

    // inactivity timeout, then cancel racing a coin
    coin(30);
    for (int i = 0; i < TMO - 1; i++) step();
    chk("p5_pre_tmo", state, 1);
    step();
    chk("p5_tmo", state, 3);
    chk("p5_amt", change_amount, 30);
    take_change();
    coin(20);
    coin_valid = 1; coin_value = 8'd5; cancel(); coin_valid = 0;
    chk("p5_rej", coin_reject, 1);
    chk("p5_amt2", change_amount, 20);
    take_change();

    // zero-cost item, same-cycle restock, same-cycle cost write
    wr_cost(6, 0); restock(6, 1);
    coin(5);
    buy_button = 1; item_sel = 3'd6; restock_en = 1; restock_idx = 3'd6; restock_qty = 4'd3;
    cost_wr_en = 1; cost_wr_idx = 3'd6; cost_wr_data = 8'd99;
    step();
    buy_button = 0; restock_en = 0; cost_wr_en = 0;
    chk("zc_credit", credit, 5);
    dispense_ready = 1; step(); dispense_ready = 0;
    take_change();

    // reset mid-handshake
    wr_cost(3, 5); restock(3, 2);
    coin(10); buy(3);
    chk("p6_dv", dispense_valid, 1);
    reset = 0; step(); reset = 1;
    chk("p6_idle", state, 0);
    chk("p6_dv0", dispense_valid, 0);
    chk("p6_credit", credit, 0);
    coin(10); buy(3);
    chk("p6_tbl_clr", err_sold_out, 1);
    cancel(); take_change();

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      int cv;
      reset          = ($urandom_range(0, 299) != 0);
      coin_valid     = ($urandom_range(0, 9) < 3);
      cv             = $urandom_range(0, 7);
      coin_value     = (cv == 0) ? 8'd0 : (cv == 1) ? 8'd5 : (cv == 2) ? 8'd10 :
                       (cv == 3) ? 8'd25 : (cv == 4) ? 8'd50 : (cv == 5) ? 8'd100 :
                       MW'($urandom_range(0, 255));
      buy_button     = ($urandom_range(0, 9) == 0);
      cancel_button  = ($urandom_range(0, 29) == 0);
      item_sel       = IW'($urandom_range(0, NI - 1));
      cost_wr_en     = ($urandom_range(0, 19) == 0);
      cost_wr_idx    = IW'($urandom_range(0, NI - 1));
      cost_wr_data   = MW'($urandom_range(0, 80));
      restock_en     = ($urandom_range(0, 19) == 0);
      restock_idx    = ($urandom_range(0, 1) == 0) ? item_sel : IW'($urandom_range(0, NI - 1));
      restock_qty    = SW'($urandom_range(0, 15));
      dispense_ready = ($urandom_range(0, 1) == 0);
      change_ready   = ($urandom_range(0, 1) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
